// File: rtl/simplebus_arb_pkg.sv
// Shared types and default sizing for the simplebus round-robin arbiter.
package simplebus_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int unsigned NREQ_DEF     = 4;
  localparam int unsigned HOLD_MAX_DEF = 8;

endpackage

// File: rtl/simplebus_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping modulo NREQ.
module simplebus_rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] pick,
  output logic            any
);

  always_comb begin : p_scan
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      // One extra bit keeps rr_ptr + i from overflowing before the wrap.
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/simplebus_arbiter.sv
// Round-robin owner/sequencer for the single-bit simplebus data wire.
// Optional hold-time revoke enabled by defining SIMPLEBUS_ARB_TIMEOUT_EN.
module simplebus_arbiter
  import simplebus_arb_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  input  logic [NREQ-1:0] data_in,
  output logic [NREQ-1:0] gnt,
  output logic            bus_out,
  output logic            busy,
  output logic [NREQ-1:0] timeout
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 16 || HOLD_MAX < 2) begin : g_param_chk
    $error("simplebus_arbiter: NREQ must be 2..16 and HOLD_MAX at least 2");
  end

  arb_state_e      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   own_idx;
  logic [PW-1:0]   nxt_ptr;
  logic [NREQ-1:0] pick;
  logic            pick_any;
  logic            own_req;
  logic            own_last;
  logic            normal_end;
  logic            hold_exp;

  simplebus_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .any    (pick_any)
  );

  always_comb begin
    own_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) own_idx = PW'(i);
    end
  end

  assign nxt_ptr    = (own_idx == PW'(NREQ-1)) ? '0 : own_idx + PW'(1);
  assign own_req    = |(gnt & req);
  assign own_last   = |(gnt & req & last);
  // A dropped request ends the transfer just like a final beat.
  assign normal_end = !own_req || own_last;

  assign busy    = (state == OWN);
  assign bus_out = |(gnt & data_in);

`ifdef SIMPLEBUS_ARB_TIMEOUT_EN
  localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [CW-1:0] hold_cnt;

  assign hold_exp = (hold_cnt == CW'(HOLD_MAX-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= '0;
    end else begin
      // A final beat or abandon in the expiry cycle wins; no pulse then.
      timeout  <= (state == OWN && hold_exp && !normal_end) ? gnt : '0;
      hold_cnt <= (state == OWN) ? hold_cnt + CW'(1) : '0;
    end
  end
`else
  assign hold_exp = 1'b0;
  assign timeout  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state <= OWN;
            gnt   <= pick;
          end
        end
        OWN: begin
          // Dropping gnt here guarantees one idle cycle before the next owner.
          if (normal_end || hold_exp) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

endmodule

// File: tb/tb_simplebus_arbiter.sv
// Randomized self-checking bench for simplebus_arbiter against a transfer-level reference model.
module tb_simplebus_arbiter;

  localparam int NREQ     = 4;
  localparam int HOLD_MAX = 8;
`ifdef SIMPLEBUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] last;
  logic [NREQ-1:0] data_in;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] timeout;
  logic            bus_out;
  logic            busy;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: current owner (-1 when the bus is free), rotation start, OWN cycles so far.
  int              m_owner;
  int              m_ptr;
  int              m_cnt;
  logic [NREQ-1:0] m_to;

  int              obs_order[$];
  logic [NREQ-1:0] prev_gnt;

  always #5 clk = ~clk;

  simplebus_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .last    (last),
    .data_in (data_in),
    .gnt     (gnt),
    .bus_out (bus_out),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_to    = '0;
  endtask

  task automatic model_step();
    int o;
    bit fin;
    m_to = '0;
    if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        o = (m_ptr + k) % NREQ;
        if (req[o]) begin
          m_owner = o;
          m_cnt   = 0;
          break;
        end
      end
    end else begin
      o   = m_owner;
      fin = !req[o] || last[o];
      if (!fin && TO_EN && m_cnt == HOLD_MAX - 1) begin
        m_to[o] = 1'b1;
        fin     = 1'b1;
      end
      if (fin) begin
        m_owner = -1;
        m_ptr   = (o + 1) % NREQ;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_outputs();
    check("gnt", 32'(gnt), 32'(onehot(m_owner)));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("bus_out", 32'(bus_out), (m_owner >= 0) ? 32'(data_in[m_owner]) : 32'd0);
    check("timeout", 32'(timeout), 32'(m_to));
    check("rr_ptr", 32'(dut.rr_ptr), 32'(m_ptr));
    if (gnt != '0 && prev_gnt == '0) obs_order.push_back(idx_of(gnt));
    prev_gnt = gnt;
  endtask

  // Inputs are applied 1 time unit after the rising edge and checked on the falling edge.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
    req     = r;
    last    = l;
    data_in = NREQ'($urandom);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] l;
    bit              done;

    rst_n    = 1'b0;
    req      = '0;
    last     = '0;
    data_in  = '0;
    prev_gnt = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contention: everyone requests, each owner ends on its second beat.
    obs_order.delete();
    for (int c = 0; c < 15; c++)
      step('1, (m_owner >= 0 && m_cnt == 1) ? onehot(m_owner) : '0);
    step('0, '0);
    check("order_len", 32'(obs_order.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_order.size(); i++)
      check($sformatf("order%0d", i), 32'(obs_order[i]), 32'(i % NREQ));

    // Single requester, three beats with last on the third.
    for (int c = 0; c < 3; c++) step(4'b0010, '0);
    step(4'b0010, 4'b0010);
    step('0, '0);
    check("single_ptr", 32'(dut.rr_ptr), 32'd2);
    step('0, '0);

    // Abandon by owner 2.
    for (int c = 0; c < 3; c++) step(4'b0100, '0);
    step('0, '0);
    check("abandon_ptr", 32'(dut.rr_ptr), 32'd3);
    check("abandon_to", 32'(timeout), 32'd0);
    step('0, '0);

    // Long hold with no final beat; revoked only when the timeout build is used.
    for (int c = 0; c < 14; c++) step(4'b0011, '0);
    step('0, '0);
    step('0, '0);

    // Final beat exactly in the last allowed hold cycle.
    done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      r = done ? '0 : 4'b0001;
      l = (!done && m_owner == 0 && m_cnt == HOLD_MAX - 1) ? 4'b0001 : '0;
      if (l != '0) done = 1'b1;
      step(r, l);
    end
    step('0, '0);

    // Asynchronous reset while requester 2 owns the bus.
    step(4'b0100, '0);
    step(4'b0100, '0);
    check("pre_rst_gnt", 32'(gnt), 32'(4'b0100));
    req  = 4'b0100;
    last = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0001, '0);
    step(4'b0001, 4'b0001);
    step('0, '0);

    // Random traffic.
    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      l = NREQ'($urandom) & NREQ'($urandom) & NREQ'($urandom);
      step(r, l);
    end
    step('0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
